// File: rtl/cdc_xfer_arbiter.sv
// cdc_xfer_arbiter: source-domain controller sharing one multi-bit crossing
// channel among NUM_REQ requesters. A round-robin winner's word is latched
// into data_out and held for the whole toggle handshake, so the destination
// can sample the bus safely once it sees req_tgl change.
module cdc_xfer_arbiter #(
   parameter int WIDTH     = 3,
   parameter int NUM_REQ   = 4,
   parameter int SETUP_CYC = 2,
   parameter int TIMEOUT   = 16
) (
   input  logic                           clk_A,
   input  logic                           rst_n,
   input  logic [NUM_REQ-1:0]             req,
   input  logic [NUM_REQ*(WIDTH+1)-1:0]   data_in,
   input  logic                           ack_tgl,
   output logic [WIDTH:0]                 data_out,
   output logic                           req_tgl,
   output logic [NUM_REQ-1:0]             gnt,
   output logic [NUM_REQ-1:0]             done,
   output logic                           busy,
   output logic                           timeout_err
);

   localparam int IDX_W  = $clog2(NUM_REQ);
   localparam int CNT_W  = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;
   localparam int TCNT_W = $clog2(TIMEOUT + 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SETUP = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic [1:0]         state_r;
   logic [IDX_W-1:0]   ptr_r;
   logic [IDX_W-1:0]   gidx_r;
   logic [CNT_W-1:0]   cnt_r;
   logic [TCNT_W-1:0]  tcnt_r;
   logic               ack_s1;
   logic               ack_s2;

   logic               win_found_s;
   logic [IDX_W-1:0]   win_idx_s;
   logic [IDX_W-1:0]   cand_idx_s;
   logic [WIDTH:0]     win_word_s;
   logic [NUM_REQ-1:0] win_onehot_s;
   logic [IDX_W-1:0]   ptr_next_s;

   // Round-robin scan: first requesting index at or above the pointer, wrapping.
   always_comb begin
      win_found_s = 1'b0;
      win_idx_s   = {IDX_W{1'b0}};
      cand_idx_s  = {IDX_W{1'b0}};
      for (int k = 0; k < NUM_REQ; k++) begin
         cand_idx_s = IDX_W'((int'(ptr_r) + k) % NUM_REQ);
         if (!win_found_s && req[cand_idx_s]) begin
            win_found_s = 1'b1;
            win_idx_s   = cand_idx_s;
         end else begin
            win_found_s = win_found_s;
         end
      end
   end

   // Word mux and one-hot decode of the winning index.
   always_comb begin
      win_word_s   = {(WIDTH+1){1'b0}};
      win_onehot_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx_s;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (win_idx_s == IDX_W'(k)) begin
            win_word_s = data_in[k*(WIDTH+1) +: WIDTH+1];
         end else begin
            win_word_s = win_word_s;
         end
      end
   end

   // Pointer moves to the requester just after the one being served.
   always_comb begin
      if (gidx_r == IDX_W'(NUM_REQ - 1)) begin
         ptr_next_s = {IDX_W{1'b0}};
      end else begin
         ptr_next_s = gidx_r + 1'b1;
      end
   end

   // Two-flop synchronizer for the destination's acknowledge toggle.
   always_ff @(posedge clk_A) begin
      if (!rst_n) begin
         ack_s1 <= 1'b0;
         ack_s2 <= 1'b0;
      end else begin
         ack_s1 <= ack_tgl;
         ack_s2 <= ack_s1;
      end
   end

   // Handshake sequencer: grant/load, setup delay, wait for ack, completion pulse.
   always_ff @(posedge clk_A) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         data_out    <= {(WIDTH+1){1'b0}};
         req_tgl     <= 1'b0;
         gnt         <= {NUM_REQ{1'b0}};
         done        <= {NUM_REQ{1'b0}};
         busy        <= 1'b0;
         timeout_err <= 1'b0;
         ptr_r       <= {IDX_W{1'b0}};
         gidx_r      <= {IDX_W{1'b0}};
         cnt_r       <= {CNT_W{1'b0}};
         tcnt_r      <= {TCNT_W{1'b0}};
      end else begin
         done <= {NUM_REQ{1'b0}};
         case (state_r)
            ST_IDLE: begin
               if (win_found_s) begin
                  data_out <= win_word_s;
                  gnt      <= win_onehot_s;
                  gidx_r   <= win_idx_s;
                  cnt_r    <= {CNT_W{1'b0}};
                  busy     <= 1'b1;
                  state_r  <= ST_SETUP;
               end else begin
                  busy <= 1'b0;
               end
            end
            ST_SETUP: begin
               if (cnt_r == CNT_W'(SETUP_CYC - 1)) begin
                  req_tgl <= ~req_tgl;
                  tcnt_r  <= {TCNT_W{1'b0}};
                  state_r <= ST_WAIT;
               end else begin
                  cnt_r <= cnt_r + 1'b1;
               end
            end
            ST_WAIT: begin
               if (ack_s2 == req_tgl) begin
                  done    <= gnt;
                  state_r <= ST_DONE;
               end else begin
                  // Keep waiting after a timeout; a late ack still completes.
                  if (tcnt_r != TCNT_W'(TIMEOUT)) begin
                     tcnt_r <= tcnt_r + 1'b1;
                  end else begin
                     tcnt_r <= tcnt_r;
                  end
                  if (tcnt_r >= TCNT_W'(TIMEOUT - 1)) begin
                     timeout_err <= 1'b1;
                  end else begin
                     timeout_err <= timeout_err;
                  end
               end
            end
            ST_DONE: begin
               ptr_r   <= ptr_next_s;
               gnt     <= {NUM_REQ{1'b0}};
               busy    <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               gnt     <= {NUM_REQ{1'b0}};
               busy    <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cdc_xfer_arbiter.sv
// tb_cdc_xfer_arbiter: directed scenarios plus randomized traffic, with a
// timestamp-based transfer model compared against every output each cycle.
module tb_cdc_xfer_arbiter;

   localparam int W  = 3;
   localparam int WD = W + 1;
   localparam int N  = 4;
   localparam int IW = $clog2(N);
   localparam int SC = 2;
   localparam int TO = 16;

   logic               clk_A = 1'b0;
   logic               rst_n = 1'b0;
   logic [N-1:0]       req = '0;
   logic [N*WD-1:0]    data_in = '0;
   logic               ack_tgl = 1'b0;
   logic [W:0]         data_out;
   logic               req_tgl;
   logic [N-1:0]       gnt;
   logic [N-1:0]       done;
   logic               busy;
   logic               timeout_err;

   int total = 0;
   int bad   = 0;

   cdc_xfer_arbiter #(.WIDTH(W), .NUM_REQ(N), .SETUP_CYC(SC), .TIMEOUT(TO)) dut (
      .clk_A(clk_A), .rst_n(rst_n), .req(req), .data_in(data_in), .ack_tgl(ack_tgl),
      .data_out(data_out), .req_tgl(req_tgl), .gnt(gnt), .done(done),
      .busy(busy), .timeout_err(timeout_err)
   );

   always #5 clk_A = ~clk_A;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model (timestamp based) ----------------
   int         n_edge = 0;
   bit         armed = 1'b0;
   bit         m_busy, m_tgl, m_err, m_s1, m_s2, m_old_s2;
   int         m_ptr, m_gidx, m_t0, m_done_edge, mk, mc;
   logic [W:0] m_data;

   initial begin
      forever begin
         @(posedge clk_A);
         n_edge = n_edge + 1;
         if (!rst_n) begin
            m_busy = 1'b0; m_tgl = 1'b0; m_err = 1'b0; m_s1 = 1'b0; m_s2 = 1'b0;
            m_ptr = 0; m_gidx = 0; m_done_edge = -1; m_data = '0; armed = 1'b1;
         end else begin
            m_old_s2 = m_s2; m_s2 = m_s1; m_s1 = ack_tgl;
            if (!m_busy) begin
               if (req != '0) begin
                  for (int k = 0; k < N; k++) begin
                     mc = (m_ptr + k) % N;
                     if (req[IW'(mc)]) begin
                        m_gidx = mc;
                        break;
                     end
                  end
                  m_busy = 1'b1; m_t0 = n_edge; m_done_edge = -1;
                  m_data = WD'(data_in >> (m_gidx * WD));
               end
            end else if (m_done_edge >= 0) begin
               m_ptr = (m_gidx + 1) % N; m_busy = 1'b0; m_done_edge = -1;
            end else begin
               mk = n_edge - m_t0;
               if (mk == SC) m_tgl = ~m_tgl;
               else if (mk > SC) begin
                  if (m_old_s2 == m_tgl) m_done_edge = n_edge;
                  else if (mk - SC >= TO) m_err = 1'b1;
               end
            end
         end
      end
   end

   // Every-cycle comparison of all outputs against the model.
   initial begin
      forever begin
         @(negedge clk_A);
         if (armed) begin
            check("data_out", 32'(data_out), 32'(m_data));
            check("gnt", 32'(gnt), m_busy ? 32'(1 << m_gidx) : 32'd0);
            check("done", 32'(done), (m_busy && m_done_edge == n_edge) ? 32'(1 << m_gidx) : 32'd0);
            check("busy", 32'(busy), 32'(m_busy));
            check("req_tgl", 32'(req_tgl), 32'(m_tgl));
            check("timeout_err", 32'(timeout_err), 32'(m_err));
         end
      end
   end

   // ---------------- destination emulator ----------------
   bit resp_en = 1'b1;
   int resp_dly = 0;
   int spur_req = 0, spur_done = 0;
   bit seen = 1'b0;
   int wcnt = 0;

   initial begin
      forever begin
         @(negedge clk_A);
         if (!rst_n) begin
            ack_tgl = 1'b0; seen = 1'b0; wcnt = 0;
         end else if (spur_req != spur_done) begin
            ack_tgl = ~ack_tgl; spur_done = spur_done + 1;
         end else if (resp_en && req_tgl != seen) begin
            if (wcnt >= resp_dly) begin
               ack_tgl = req_tgl; seen = req_tgl; wcnt = 0;
            end else begin
               wcnt = wcnt + 1;
            end
         end
      end
   end

   // Grant-order recorder for the fairness scenario.
   bit collect = 1'b0;
   int order[$];
   initial begin
      forever begin
         @(negedge clk_A);
         if (collect && done != '0) begin
            for (int k = 0; k < N; k++) if (done[IW'(k)]) order.push_back(k);
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic step(input int k);
      repeat (k) @(posedge clk_A);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step(2);
      rst_n = 1'b1;
   endtask

   task automatic set_word(input int i, input logic [W:0] v);
      data_in[i*WD +: WD] = v;
   endtask

   task automatic wait_done(input string nm, input logic [N-1:0] mask, input int budget);
      for (int i = 0; i < budget; i++) begin
         step(1);
         if (done != '0) break;
      end
      check(nm, 32'(done), 32'(mask));
   endtask

   task automatic wait_tgl(input string nm, input int budget);
      logic start;
      bit   seen_chg;
      start = req_tgl;
      seen_chg = 1'b0;
      for (int i = 0; i < budget; i++) begin
         step(1);
         if (req_tgl != start) begin
            seen_chg = 1'b1;
            break;
         end
      end
      check(nm, 32'(seen_chg), 32'd1);
   endtask

   int exp_order[6] = '{0, 1, 2, 3, 0, 1};
   int msk;

   // ---------------- stimulus ----------------
   initial begin
      step(3);
      rst_n = 1'b1;
      check("reset data_out", 32'(data_out), 32'd0);
      check("reset gnt", 32'(gnt), 32'd0);
      check("reset req_tgl", 32'(req_tgl), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset timeout_err", 32'(timeout_err), 32'd0);

      // Single transfer with hand-derived timing.
      set_word(0, 4'hA); req = 4'b0001; resp_en = 1'b1; resp_dly = 1;
      step(1);
      check("single data_out", 32'(data_out), 32'hA);
      check("single gnt", 32'(gnt), 32'h1);
      check("single busy", 32'(busy), 32'd1);
      req = 4'b0000;
      step(1);
      check("single tgl e1", 32'(req_tgl), 32'd0);
      step(1);
      check("single tgl e2", 32'(req_tgl), 32'd1);
      step(3);
      check("single done e5", 32'(done), 32'h0);
      step(1);
      check("single done e6", 32'(done), 32'h1);
      check("single gnt e6", 32'(gnt), 32'h1);
      step(1);
      check("single done e7", 32'(done), 32'h0);
      check("single busy e7", 32'(busy), 32'd0);
      check("single gnt e7", 32'(gnt), 32'h0);

      // Fairness with all requesters active.
      do_reset();
      resp_dly = 0;
      data_in = N*WD'($urandom);
      req = 4'b1111;
      collect = 1'b1;
      for (int i = 0; i < 200; i++) begin
         step(1);
         if (order.size() >= 8) break;
      end
      collect = 1'b0;
      req = 4'b0000;
      check("fair count", 32'(order.size() >= 8), 32'd1);
      if (order.size() >= 8) begin
         for (int i = 0; i < 6; i++) check("fair order", 32'(order[i]), 32'(exp_order[i]));
         for (int w = 0; w < 2; w++) begin
            msk = 0;
            for (int j = 0; j < 4; j++) msk = msk | (1 << order[w*4 + j]);
            check("fair rotation", 32'(msk), 32'hF);
         end
      end
      step(12);

      // Stability: data_out held while another requester arrives.
      do_reset();
      resp_en = 1'b0;
      set_word(0, 4'hA); req = 4'b0001;
      wait_tgl("stab tgl", 20);
      req = 4'b0100; set_word(2, 4'h5); set_word(0, 4'h3);
      for (int i = 0; i < 5; i++) begin
         step(1);
         check("stab hold", 32'(data_out), 32'hA);
      end
      resp_en = 1'b1;
      wait_done("stab done0", 4'b0001, 20);
      check("stab data at done", 32'(data_out), 32'hA);
      for (int i = 0; i < 10; i++) begin
         step(1);
         if (gnt == 4'b0100) break;
      end
      check("stab gnt2", 32'(gnt), 32'h4);
      check("stab data2", 32'(data_out), 32'h5);
      req = 4'b0000;
      wait_done("stab done2", 4'b0100, 20);
      step(2);

      // Timeout, then a late ack.
      do_reset();
      resp_en = 1'b0;
      set_word(1, 4'h7); req = 4'b0010;
      wait_tgl("to tgl", 20);
      req = 4'b0000;
      step(15);
      check("to before", 32'(timeout_err), 32'd0);
      step(1);
      check("to rise", 32'(timeout_err), 32'd1);
      step(5);
      check("to sticky", 32'(timeout_err), 32'd1);
      resp_en = 1'b1;
      wait_done("to late done", 4'b0010, 10);
      check("to after done", 32'(timeout_err), 32'd1);
      step(2);
      check("to idle err", 32'(timeout_err), 32'd1);

      // Reset in the middle of a handshake.
      set_word(2, 4'h9); req = 4'b0100;
      wait_done("mid pre done", 4'b0100, 20);
      req = 4'b0000;
      step(2);
      resp_en = 1'b0;
      set_word(3, 4'hC); req = 4'b1000;
      wait_tgl("mid tgl", 20);
      req = 4'b0000;
      check("mid tgl high", 32'(req_tgl), 32'd1);
      step(2);
      rst_n = 1'b0;
      step(1);
      check("mid rst tgl", 32'(req_tgl), 32'd0);
      check("mid rst data", 32'(data_out), 32'd0);
      check("mid rst gnt", 32'(gnt), 32'd0);
      check("mid rst busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      resp_en = 1'b1;
      set_word(0, 4'h1); req = 4'b1001;
      step(1);
      check("mid first grant", 32'(gnt), 32'h1);
      req = 4'b0000;
      wait_done("mid done", 4'b0001, 20);
      step(2);

      // Spurious ack toggle while idle.
      spur_req = spur_req + 1;
      for (int i = 0; i < 8; i++) begin
         step(1);
         check("spur no done", 32'(done), 32'd0);
         check("spur idle", 32'(busy), 32'd0);
      end
      set_word(0, 4'h6); req = 4'b0001;
      wait_done("spur next done", 4'b0001, 20);
      req = 4'b0000;
      step(2);
      set_word(1, 4'hE); req = 4'b0010;
      wait_done("spur second done", 4'b0010, 20);
      req = 4'b0000;
      step(2);

      // Randomized traffic.
      for (int i = 0; i < 1500; i++) begin
         step(1);
         if ($urandom_range(0, 3) == 0) begin
            req = N'($urandom_range(0, 15));
            data_in = N*WD'($urandom);
            resp_dly = $urandom_range(0, 3);
         end
         resp_en = ($urandom_range(0, 19) != 0);
         if (!busy && $urandom_range(0, 199) == 0) spur_req = spur_req + 1;
         if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
         else rst_n = 1'b1;
      end
      rst_n = 1'b1;
      req = '0;
      step(40);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cdc_xfer_arbiter.md
Name: cdc_xfer_arbiter

Overview:
- Source-domain controller that shares one multi-bit clock-domain-crossing data channel among NUM_REQ requesters.
- Round-robin arbitrates the requesters, then loads the winner's word into a hold register (data_out), which feeds the crossing datapath.
- Signals the transfer with a toggle (req_tgl) and waits for the destination's returned toggle (ack_tgl), which it synchronizes internally.
- Keeps data_out stable for the whole handshake, so the multi-bit crossing is safe.

Parameters:
- WIDTH, 3: data MSB index; words are [WIDTH:0].
- NUM_REQ, 4: number of requesters, minimum 2.
- SETUP_CYC, 2: cycles data_out is stable before req_tgl toggles, minimum 1.
- TIMEOUT, 16: WAIT_ACK cycles before timeout_err is set, minimum 1.

Ports:
- clk_A  input  1  source-domain clock; the only clock.
- rst_n  input  1  reset, synchronous, active-low.
- req  input  NUM_REQ  per-requester transfer request, level.
- data_in  input  NUM_REQ*(WIDTH+1)  packed words; requester i occupies bits [i*(WIDTH+1) +: WIDTH+1].
- ack_tgl  input  1  destination acknowledge toggle; asynchronous to clk_A.
- data_out  output  WIDTH+1  held word driven to the crossing datapath.
- req_tgl  output  1  transfer toggle driven to the destination.
- gnt  output  NUM_REQ  one-hot grant; high from SETUP through DONE.
- done  output  NUM_REQ  one-cycle completion pulse for the granted requester.
- busy  output  1  high in every state except IDLE.
- timeout_err  output  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset (rst_n low at a clk_A edge):
  - state goes to IDLE.
  - data_out, req_tgl, gnt, done, busy and timeout_err go to 0.
  - Both ack synchronizer flops go to 0; the round-robin pointer goes to 0; all counters go to 0.
  - Reset applies in any state, including mid-handshake. The destination must be reset together with this block.
- ack_tgl passes through a 2-flop synchronizer (ack_s1, then ack_s2). Only ack_s2 is used.
- IDLE:
  - If req is nonzero, pick the winner: the first set bit scanning upward from the pointer, modulo NUM_REQ.
  - At that edge: data_out gets the winner's word, gnt gets the one-hot winner, counter gets 0, state goes to SETUP.
  - Changes of ack_s2 while in IDLE are ignored.
- SETUP:
  - The counter increments each cycle.
  - On the edge where counter equals SETUP_CYC-1: req_tgl inverts, the timeout counter clears, state goes to WAIT_ACK.
  - With SETUP_CYC=1, req_tgl toggles on the first edge after the data load.
- WAIT_ACK:
  - If ack_s2 equals req_tgl, go to DONE.
  - Otherwise the timeout counter increments, saturating. When it reaches TIMEOUT, timeout_err is set and stays set.
  - After a timeout the block keeps waiting; a late ack still completes the transfer normally.
- DONE, exactly one cycle:
  - done[granted] is high and gnt is still high.
  - At the next edge: pointer gets granted+1 modulo NUM_REQ, gnt gets 0, state goes to IDLE.
- Registered-output timing: done is asserted during the DONE cycle. busy drops in the cycle after DONE.
- Requester rules:
  - A requester must hold data_in stable only until its gnt bit rises.
  - A req still high when the block returns to IDLE is a new request. The pointer guarantees no requester is starved.
- data_out and the granted index change only in IDLE.
- Minimum transfer time is 1 + SETUP_CYC + 3 + 1 cycles when the ack is returned immediately.
- Deasserting req during a transfer does not abort it.
- req_tgl toggles exactly once per transfer.

Test Plan:
- Single transfer. SETUP_CYC=2; req=0001 with word 0xA at edge 0. Required: data_out=0xA and gnt=0001 after edge 0; req_tgl goes 0 to 1 after edge 2. Bench inverts ack_tgl after edge 3. Required: done=0001 high for exactly one cycle, starting after the 3rd edge following the ack change; busy low one cycle later.
- Fairness. req=1111 held continuously, with immediate acks. Required: grant order 0,1,2,3,0,1; each requester gets exactly one done per rotation.
- Stability. Requester 2 raises req with word 0x5 while requester 0's 0xA transfer is in WAIT_ACK. Required: data_out stays 0xA until requester 0's DONE; then requester 2 is granted and data_out becomes 0x5.
- Timeout. TIMEOUT=16; no ack. Required: timeout_err rises after the 16th WAIT_ACK cycle and stays high. A later ack toggle then yields a normal done pulse, and timeout_err remains 1.
- Reset mid-handshake. rst_n low at a WAIT_ACK edge with req_tgl=1. Required: after that edge req_tgl, data_out, gnt and busy are 0 and the state is IDLE. The next transfer grants requester 0 first.
- Spurious ack. Toggle ack_tgl while in IDLE with no req. Required: no done pulse and no state change. The next transfer still completes on the correct toggle parity.
